alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/alu_sequencer.sv | 65 ++++++
 tb/tb_alu_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, ALU and response signals of the sequencer; master = environment side (drives cmd_*, alu_result, rsp_ready), slave = sequencer side
interface alu_sequencer_if #(parameter int DATA_WIDTH = 8);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd_opcode;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic [DATA_WIDTH-1:0] alu_operand_a;
  logic [DATA_WIDTH-1:0] alu_operand_b;
  logic [3:0]            alu_opcode;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_error;
  logic                  busy;
  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    input  cmd_ready, alu_operand_a, alu_operand_b, alu_opcode, rsp_valid, rsp_result, rsp_error, busy
  );
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    output cmd_ready, alu_operand_a, alu_operand_b, alu_opcode, rsp_valid, rsp_result, rsp_error, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: queues commands in a FIFO, issues them in order to an external registered ALU and returns one response each; ports clk, rst_n (async active-low), bus (alu_sequencer_if.slave)
module alu_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  alu_sequencer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t                state, state_d;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [3:0]            op_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] a_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] b_mem  [FIFO_DEPTH];
  logic                  push, pop, legal;
  assign bus.cmd_ready = count < (AW+1)'(FIFO_DEPTH);
  assign bus.busy      = state != IDLE || count != '0;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign legal         = bus.alu_opcode[3:1] == 3'b000;
  always_comb begin
    pop     = (state == IDLE || (state == HOLD && bus.rsp_valid && bus.rsp_ready)) && count != '0;
    state_d = state == ISSUE ? WAIT :
              state == WAIT  ? HOLD :
              pop            ? ISSUE :
              (state == HOLD && bus.rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (push) begin
      op_mem[wr_ptr] <= bus.cmd_opcode;
      a_mem[wr_ptr]  <= bus.cmd_a;
      b_mem[wr_ptr]  <= bus.cmd_b;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      bus.alu_opcode    <= '0;
      bus.alu_operand_a <= '0;
      bus.alu_operand_b <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_result    <= '0;
      bus.rsp_error     <= 1'b0;
    end else begin
      state <= state_d;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr            <= rd_ptr + AW'(1);
        bus.alu_opcode    <= op_mem[rd_ptr];
        bus.alu_operand_a <= a_mem[rd_ptr];
        bus.alu_operand_b <= b_mem[rd_ptr];
      end
      if (state == WAIT) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_result <= legal ? bus.alu_result : '0;
        bus.rsp_error  <= !legal;
      end else if (state == HOLD && bus.rsp_ready)
        bus.rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of the ALU sequencer against hand-computed responses, with a registered add/subtract ALU model
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int got;
  logic [7:0] res [8];
  logic       err [8];
  int         stamp [8];
  alu_sequencer_if bus();
  alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    bus.alu_result <= bus.alu_opcode == 4'h1 ? bus.alu_operand_a - bus.alu_operand_b
                                             : bus.alu_operand_a + bus.alu_operand_b;
  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic collect(input int n);
    logic acc;
    got = 0;
    for (int c = 0; c < 100 && got < n; c++) begin
      acc = bus.cmd_valid && bus.cmd_ready;
      if (bus.rsp_valid && bus.rsp_ready) begin
        res[got] = bus.rsp_result;
        err[got] = bus.rsp_error;
        stamp[got] = c;
        got++;
      end
      @(negedge clk);
      if (acc) bus.cmd_valid = 1'b0;
    end
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_error, bus.rsp_result, bus.alu_opcode, bus.alu_operand_a, bus.alu_operand_b} !== {4'b1000, 8'h00, 4'h0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_async: got ready=%b busy=%b rv=%b re=%b rr=%h op=%h a=%h b=%h expected ready=1 others 0", bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_error, bus.rsp_result, bus.alu_opcode, bus.alu_operand_a, bus.alu_operand_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL reset_held: got ready=%b busy=%b rv=%b expected 1 0 0", bus.cmd_ready, bus.busy, bus.rsp_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single_add;
    bus.rsp_ready  = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 4'h0;
    bus.cmd_a      = 8'h25;
    bus.cmd_b      = 8'h13;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL add_busy_e0: got %b expected 1", bus.busy);
    end
    @(negedge clk);
    checks++;
    if ({bus.alu_opcode, bus.alu_operand_a, bus.alu_operand_b} !== {4'h0, 8'h25, 8'h13}) begin
      failures++;
      $display("FAIL add_alu_e1: got %h/%h/%h expected 0/25/13", bus.alu_opcode, bus.alu_operand_a, bus.alu_operand_b);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_early_rsp_e2: got rsp_valid=%b expected 0", bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_result} !== {2'b10, 8'h38}) begin
      failures++;
      $display("FAIL add_rsp_e3: got v=%b e=%b r=%h expected v=1 e=0 r=38", bus.rsp_valid, bus.rsp_error, bus.rsp_result);
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      failures++;
      $display("FAIL add_done_e4: got rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
    end
  endtask
  task automatic test_wrap_borrow;
    bus.rsp_ready = 1'b1;
    push(4'h0, 8'hFF, 8'h02);
    push(4'h1, 8'h03, 8'h05);
    collect(2);
    checks++;
    if (got !== 2) begin
      failures++;
      $display("FAIL wrap_count: got %0d responses expected 2", got);
    end else begin
      checks++;
      if ({res[0], err[0], res[1], err[1]} !== {8'h01, 1'b0, 8'hFE, 1'b0}) begin
        failures++;
        $display("FAIL wrap_values: got %h/%b %h/%b expected 01/0 fe/0", res[0], err[0], res[1], err[1]);
      end
      checks++;
      if (stamp[1] - stamp[0] !== 3) begin
        failures++;
        $display("FAIL back_to_back_spacing: got %0d cycles expected 3", stamp[1] - stamp[0]);
      end
      checks++;
      if (stamp[0] !== 2) begin
        failures++;
        $display("FAIL wrap_first_latency: got slot %0d expected 2", stamp[0]);
      end
    end
  endtask
  task automatic test_backpressure;
    logic [7:0] exp_r [6];
    exp_r = '{8'h02, 8'h04, 8'h06, 8'h10, 8'h1B, 8'h00};
    bus.rsp_ready = 1'b0;
    push(4'h0, 8'h01, 8'h01);
    push(4'h0, 8'h02, 8'h02);
    push(4'h1, 8'h09, 8'h03);
    push(4'h0, 8'h08, 8'h08);
    push(4'h1, 8'h20, 8'h05);
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_result} !== {2'b01, 8'h02}) begin
      failures++;
      $display("FAIL full_state: got ready=%b rv=%b rr=%h expected 0 1 02", bus.cmd_ready, bus.rsp_valid, bus.rsp_result);
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 4'h0;
    bus.cmd_a      = 8'h80;
    bus.cmd_b      = 8'h80;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.busy} !== {2'b01, 8'h02, 1'b1}) begin
      failures++;
      $display("FAIL full_hold: got ready=%b rv=%b rr=%h busy=%b expected 0 1 02 1", bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.busy);
    end
    bus.rsp_ready = 1'b1;
    collect(6);
    checks++;
    if (got !== 6) begin
      failures++;
      $display("FAIL backpressure_count: got %0d responses expected 6", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if ({res[i], err[i]} !== {exp_r[i], 1'b0}) begin
        failures++;
        $display("FAIL backpressure_rsp%0d: got %h/%b expected %h/0", i, res[i], err[i], exp_r[i]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.cmd_ready, bus.rsp_valid} !== 3'b010) begin
      failures++;
      $display("FAIL backpressure_drain: got busy=%b ready=%b rv=%b expected 0 1 0", bus.busy, bus.cmd_ready, bus.rsp_valid);
    end
  endtask
  task automatic test_illegal;
    bus.rsp_ready = 1'b1;
    push(4'h5, 8'h10, 8'h20);
    push(4'h0, 8'h10, 8'h20);
    collect(2);
    checks++;
    if (got !== 2) begin
      failures++;
      $display("FAIL illegal_count: got %0d responses expected 2", got);
    end else begin
      checks++;
      if ({res[0], err[0]} !== {8'h00, 1'b1}) begin
        failures++;
        $display("FAIL illegal_rsp: got %h/%b expected 00/1", res[0], err[0]);
      end
      checks++;
      if ({res[1], err[1]} !== {8'h30, 1'b0}) begin
        failures++;
        $display("FAIL legal_after_illegal: got %h/%b expected 30/0", res[1], err[1]);
      end
      checks++;
      if (stamp[0] !== 2) begin
        failures++;
        $display("FAIL illegal_latency: got slot %0d expected 2", stamp[0]);
      end
    end
  endtask
  task automatic test_reset_mid;
    logic seen;
    bus.rsp_ready = 1'b1;
    push(4'h0, 8'h11, 8'h22);
    push(4'h0, 8'h33, 8'h44);
    push(4'h1, 8'h55, 8'h66);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_error, bus.rsp_result, bus.alu_opcode, bus.alu_operand_a, bus.alu_operand_b} !== {4'b1000, 8'h00, 4'h0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_mid_async: got ready=%b busy=%b rv=%b re=%b rr=%h op=%h a=%h b=%h expected ready=1 others 0", bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_error, bus.rsp_result, bus.alu_opcode, bus.alu_operand_a, bus.alu_operand_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid | bus.busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_quiet: got activity=%b expected 0", seen);
    end
    push(4'h0, 8'h07, 8'h08);
    collect(1);
    checks++;
    if (got !== 1 || {res[0], err[0]} !== {8'h0F, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_resume: got n=%0d %h/%b expected 1 0f/0", got, res[0], err[0]);
    end
  endtask
  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = 4'h0;
    bus.cmd_a      = 8'h00;
    bus.cmd_b      = 8'h00;
    bus.rsp_ready  = 1'b0;
    test_reset;
    test_single_add;
    test_wrap_borrow;
    test_backpressure;
    test_illegal;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end
endmodule
